// File: rtl/stim_pkg.sv
// Shared definitions for the stim trigger responder.
// State encodings, default widths and the zero-as-one helper.
package stim_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int NP_W_DEF  = 8;
    localparam int EVT_W_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DELAY   = 3'd1,
        S_PULSE   = 3'd2,
        S_GAP     = 3'd3,
        S_REFRACT = 3'd4
    } state_e;

    function automatic logic [31:0] max1(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

endpackage

// File: rtl/stim_trigger_responder_dur_counter.sv
// Load/decrement down-counter shared by every timed state.
// zero is high on the last cycle of the loaded duration.
module stim_dur_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/stim_trigger_responder.sv
// Stim request consumer: delay, pulse train, blanking window,
// refractory lockout, accepted-event and dropped-request counters.
module stim_trigger_responder
    import stim_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NP_W  = NP_W_DEF,
    parameter int EVT_W = EVT_W_DEF
) (
    input  logic             sample_CLK_out,
    input  logic             reset,
    input  logic             enable,
    input  logic             stim_req,
    input  logic [CNT_W-1:0] delay_samples,
    input  logic [CNT_W-1:0] pulse_samples,
    input  logic [CNT_W-1:0] gap_samples,
    input  logic [NP_W-1:0]  n_pulses,
    input  logic [CNT_W-1:0] refractory_samples,
    output logic             stim_ack,
    output logic             stim_out,
    output logic             blank_out,
    output logic             busy,
    output logic [2:0]       state_out,
    output logic [EVT_W-1:0] event_count,
    output logic [EVT_W-1:0] dropped_count
);

    state_e           state;
    state_e           nxt;
    logic [CNT_W-1:0] delay_l;
    logic [CNT_W-1:0] pulse_l;
    logic [CNT_W-1:0] gap_l;
    logic [CNT_W-1:0] refr_l;
    logic [NP_W-1:0]  n_l;
    logic [NP_W-1:0]  idx;
    logic             ld;
    logic [CNT_W-1:0] ld_val;
    logic             zero;
    logic             accept;
    logic             drop;

    function automatic logic [CNT_W-1:0] dur(input logic [CNT_W-1:0] x);
        return CNT_W'(max1(32'(x)) - 32'd1);
    endfunction

    assign accept    = enable && stim_req && (state == S_IDLE);
    assign drop      = enable && stim_req && busy;
    assign state_out = state;

    stim_dur_counter #(.W(CNT_W)) u_cnt (
        .clk      (sample_CLK_out),
        .reset    (reset),
        .load     (ld),
        .load_val (ld_val),
        .zero     (zero)
    );

    // Duration counter is loaded with (len-1) on entry; exit when it reads 0.
    always_comb begin
        nxt    = state;
        ld     = 1'b0;
        ld_val = '0;
        if (!enable) begin
            nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (stim_req) begin
                        ld = 1'b1;
                        if (delay_samples == '0) begin
                            nxt    = S_PULSE;
                            ld_val = dur(pulse_samples);
                        end else begin
                            nxt    = S_DELAY;
                            ld_val = delay_samples - CNT_W'(1);
                        end
                    end
                end
                S_DELAY: begin
                    if (zero) begin
                        nxt    = S_PULSE;
                        ld     = 1'b1;
                        ld_val = dur(pulse_l);
                    end
                end
                S_PULSE: begin
                    if (zero) begin
                        if (32'(idx) < max1(32'(n_l))) begin
                            nxt    = S_GAP;
                            ld     = 1'b1;
                            ld_val = dur(gap_l);
                        end else if (refr_l != '0) begin
                            nxt    = S_REFRACT;
                            ld     = 1'b1;
                            ld_val = refr_l - CNT_W'(1);
                        end else begin
                            nxt = S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (zero) begin
                        nxt    = S_PULSE;
                        ld     = 1'b1;
                        ld_val = dur(pulse_l);
                    end
                end
                S_REFRACT: begin
                    if (zero)
                        nxt = S_IDLE;
                end
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sample_CLK_out) begin
        if (reset) begin
            state         <= S_IDLE;
            stim_ack      <= 1'b0;
            stim_out      <= 1'b0;
            blank_out     <= 1'b0;
            busy          <= 1'b0;
            event_count   <= '0;
            dropped_count <= '0;
            delay_l       <= '0;
            pulse_l       <= '0;
            gap_l         <= '0;
            refr_l        <= '0;
            n_l           <= '0;
            idx           <= '0;
        end else begin
            state     <= nxt;
            stim_ack  <= accept;
            stim_out  <= (nxt == S_PULSE);
            blank_out <= (nxt == S_PULSE) || (nxt == S_GAP) ||
                         (nxt == S_REFRACT);
            busy      <= (nxt != S_IDLE);
            if (accept) begin
                delay_l     <= delay_samples;
                pulse_l     <= pulse_samples;
                gap_l       <= gap_samples;
                refr_l      <= refractory_samples;
                n_l         <= n_pulses;
                idx         <= NP_W'(1);
                event_count <= event_count + EVT_W'(1);
            end
            if (state == S_PULSE && nxt == S_GAP)
                idx <= idx + NP_W'(1);
            if (drop && dropped_count != '1)
                dropped_count <= dropped_count + EVT_W'(1);
        end
    end

endmodule

// File: tb/tb_stim_trigger_responder.sv
// Bench for stim_trigger_responder: table-driven trains checked
// cycle by cycle against a queued waveform, plus corner sequences.
module tb_stim_trigger_responder;

    logic        sample_CLK_out = 1'b0;
    logic        reset;
    logic        enable;
    logic        stim_req;
    logic [15:0] delay_samples;
    logic [15:0] pulse_samples;
    logic [15:0] gap_samples;
    logic [7:0]  n_pulses;
    logic [15:0] refractory_samples;
    logic        stim_ack;
    logic        stim_out;
    logic        blank_out;
    logic        busy;
    logic [2:0]  state_out;
    logic [15:0] event_count;
    logic [15:0] dropped_count;

    stim_trigger_responder dut (
        .sample_CLK_out     (sample_CLK_out),
        .reset              (reset),
        .enable             (enable),
        .stim_req           (stim_req),
        .delay_samples      (delay_samples),
        .pulse_samples      (pulse_samples),
        .gap_samples        (gap_samples),
        .n_pulses           (n_pulses),
        .refractory_samples (refractory_samples),
        .stim_ack           (stim_ack),
        .stim_out           (stim_out),
        .blank_out          (blank_out),
        .busy               (busy),
        .state_out          (state_out),
        .event_count        (event_count),
        .dropped_count      (dropped_count)
    );

    always #5 sample_CLK_out = ~sample_CLK_out;

    typedef struct packed {
        logic       ack;
        logic       stim;
        logic       blank;
        logic       bsy;
        logic [2:0] st;
    } exp_t;

    typedef struct {
        int d;
        int p;
        int g;
        int n;
        int r;
        int drops;
        int exp_busy;
        int exp_hi;
    } vec_t;

    exp_t q[$];
    vec_t vt[5];
    int   total = 0;
    int   bad = 0;
    int   exp_evt = 0;
    int   exp_drop = 0;
    bit   first_ack;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge sample_CLK_out);
        #1;
    endtask

    function automatic int mx(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    function automatic void push(input logic [2:0] s);
        exp_t e;
        e.ack   = first_ack;
        e.stim  = (s == 3'd2);
        e.blank = (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
        e.bsy   = (s != 3'd0);
        e.st    = s;
        first_ack = 1'b0;
        q.push_back(e);
    endfunction

    // Expected per-sample waveform starting the sample after accept.
    function automatic void build(input vec_t v);
        first_ack = 1'b1;
        for (int i = 0; i < v.d; i++) push(3'd1);
        for (int k = 1; k <= mx(v.n); k++) begin
            for (int i = 0; i < mx(v.p); i++) push(3'd2);
            if (k < mx(v.n))
                for (int i = 0; i < mx(v.g); i++) push(3'd3);
        end
        for (int i = 0; i < v.r; i++) push(3'd4);
        push(3'd0);
        push(3'd0);
    endfunction

    function automatic int outs();
        exp_t g;
        g.ack   = stim_ack;
        g.stim  = stim_out;
        g.blank = blank_out;
        g.bsy   = busy;
        g.st    = state_out;
        return int'(g);
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        int   n;
        int   nb;
        int   nh;
        int   inj;
        exp_t e;
        delay_samples      = 16'(v.d);
        pulse_samples      = 16'(v.p);
        gap_samples        = 16'(v.g);
        n_pulses           = 8'(v.n);
        refractory_samples = 16'(v.r);
        stim_req = 1'b1;
        build(v);
        step();
        exp_evt++;
        stim_req = 1'b0;
        delay_samples      = 16'($urandom);
        pulse_samples      = 16'($urandom_range(1, 9));
        gap_samples        = 16'($urandom_range(1, 9));
        n_pulses           = 8'($urandom_range(1, 9));
        refractory_samples = 16'($urandom_range(1, 9));
        n = q.size();
        nb = 0;
        nh = 0;
        inj = 0;
        for (int c = 0; c < n; c++) begin
            e = q.pop_front();
            check($sformatf("vec%0d_cyc%0d", id, c), outs(), int'(e));
            if (busy) nb++;
            if (stim_out) nh++;
            stim_req = 1'b0;
            if (inj < v.drops && c % 4 == 1 && e.bsy) begin
                stim_req = 1'b1;
                inj++;
                exp_drop++;
            end
            step();
        end
        stim_req = 1'b0;
        check($sformatf("vec%0d_busy_len", id), nb, v.exp_busy);
        check($sformatf("vec%0d_stim_len", id), nh, v.exp_hi);
        check($sformatf("vec%0d_events", id), int'(event_count), exp_evt);
        check($sformatf("vec%0d_drops", id), int'(dropped_count), exp_drop);
    endtask

    initial begin
        int  nd;
        bit  done;
        vt[0] = '{2, 3, 1, 1, 0, 0, 5, 3};
        vt[1] = '{0, 2, 4, 3, 5, 0, 19, 6};
        vt[2] = '{0, 0, 0, 0, 0, 0, 1, 1};
        vt[3] = '{0, 2, 4, 3, 5, 3, 19, 6};
        vt[4] = '{1, 1, 2, 2, 1, 0, 6, 2};

        reset = 1'b1;
        enable = 1'b0;
        stim_req = 1'b0;
        delay_samples = '0;
        pulse_samples = '0;
        gap_samples = '0;
        n_pulses = '0;
        refractory_samples = '0;
        step();
        step();
        check("reset_outs", outs(), 0);
        check("reset_evt", int'(event_count), 0);
        check("reset_drop", int'(dropped_count), 0);
        reset = 1'b0;
        enable = 1'b1;
        repeat (7) step();

        foreach (vt[i]) run_vec(vt[i], i);

        // Request held across the IDLE-return sample: dropped, then accepted.
        delay_samples = 16'd0;
        pulse_samples = 16'd1;
        n_pulses = 8'd1;
        refractory_samples = 16'd0;
        stim_req = 1'b1;
        step();
        exp_evt++;
        check("ret_first_ack", int'({stim_ack, state_out}), 4'b1010);
        step();
        exp_drop++;
        check("ret_idle", int'({stim_ack, state_out}), 0);
        check("ret_dropped", int'(dropped_count), exp_drop);
        step();
        exp_evt++;
        check("ret_reaccept", int'({stim_ack, state_out}), 4'b1010);
        stim_req = 1'b0;
        step();
        check("ret_events", int'(event_count), exp_evt);

        // Enable dropped mid-pulse.
        delay_samples = 16'd1;
        pulse_samples = 16'd10;
        stim_req = 1'b1;
        step();
        exp_evt++;
        stim_req = 1'b0;
        check("abort_delay", int'(state_out), 1);
        step();
        step();
        check("abort_in_pulse", outs(), int'(7'b0111010));
        enable = 1'b0;
        stim_req = 1'b1;
        step();
        check("abort_outs", outs(), 0);
        step();
        check("abort_no_accept", outs(), 0);
        check("abort_evt", int'(event_count), exp_evt);
        check("abort_drop", int'(dropped_count), exp_drop);
        enable = 1'b1;
        stim_req = 1'b0;
        step();

        // Reset while in GAP.
        delay_samples = 16'd0;
        pulse_samples = 16'd1;
        gap_samples = 16'd5;
        n_pulses = 8'd2;
        stim_req = 1'b1;
        step();
        stim_req = 1'b0;
        step();
        check("gap_reached", int'(state_out), 3);
        reset = 1'b1;
        step();
        check("gap_reset_outs", outs(), 0);
        check("gap_reset_counts", int'({event_count, dropped_count}), 0);
        reset = 1'b0;
        exp_evt = 0;
        exp_drop = 0;
        step();

        // 0xFFFF delay with the request held throughout: exact length, saturation.
        delay_samples = 16'hFFFF;
        pulse_samples = 16'd1;
        n_pulses = 8'd1;
        refractory_samples = 16'd0;
        stim_req = 1'b1;
        step();
        exp_evt++;
        nd = 0;
        done = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            if (state_out == 3'd2) begin
                step();
                done = 1'b1;
                break;
            end
            if (state_out == 3'd1) nd++;
            step();
        end
        stim_req = 1'b0;
        check("long_done", int'(done), 1);
        check("long_delay_len", nd, 65535);
        check("long_idle", int'(state_out), 0);
        check("sat_drop", int'(dropped_count), 16'hFFFF);
        step();
        check("sat_hold", int'(dropped_count), 16'hFFFF);
        check("long_evt", int'(event_count), exp_evt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
